// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit that sits beside the ALU and moves
// one bit position per clock. Handles SLL, SRL, SRA and a PASS-through.
//
// Ports:
//   clk      system clock, all state updates on the rising edge
//   rst      synchronous reset, active-high
//   start    request pulse, accepted in IDLE or DONE, ignored in SHIFT
//   op       00 SLL, 01 SRL, 10 SRA, 11 PASS
//   operand  value to shift, sampled with start
//   shamt    shift amount, sampled with start
//   busy     high while the shift is in progress
//   done     one-cycle pulse, result valid
//   result   shifted value, held until the next completion or reset
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one bit per edge, count holds the shifts still to do
// DONE  | result presented for one cycle, a new start may be accepted

module seq_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic [1:0]         op_q, op_d;

    logic               accept;
    logic [WIDTH-1:0]   shifted;

    // Start is only honoured while not shifting; DONE accepts to allow
    // back-to-back requests without an idle bubble.
    assign accept = start && (state_q != SHIFT);

    always_comb begin
        shifted = sreg_q;
        unique case (op_q)
            OP_SLL:  shifted = {sreg_q[WIDTH-2:0], 1'b0};
            OP_SRL:  shifted = {1'b0, sreg_q[WIDTH-1:1]};
            OP_SRA:  shifted = {sreg_q[WIDTH-1], sreg_q[WIDTH-1:1]};
            OP_PASS: shifted = sreg_q;
            default: shifted = sreg_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sreg_d   = sreg_q;
        result_d = result_q;
        count_d  = count_q;
        op_d     = op_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    sreg_d  = operand;
                    op_d    = op;
                    count_d = shamt;
                    if ((shamt == '0) || (op == OP_PASS)) begin
                        state_d  = DONE;
                        result_d = operand;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sreg_d  = shifted;
                count_d = count_q - 1'b1;
                // count==1 means this edge performs the last shift.
                if (count_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                    result_d = shifted;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            result_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            result_q <= result_d;
            count_q  <= count_d;
            op_q     <= op_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clk;
    logic               rst;
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;

    int n_applied = 0;
    int n_miss    = 0;

    seq_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] operand;
        logic [4:0]  shamt;
        logic [31:0] exp_result;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues one request and waits for done. Inputs are scrambled right
    // after the start edge to show only the latched copies matter.
    // edges counts posedges from the start edge up to the one entering DONE.
    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         output int edges, output int busy_cyc, output logic ok);
        start   = 1'b1;
        op      = o;
        operand = d;
        shamt   = s;
        @(negedge clk);
        start   = 1'b0;
        op      = 2'b11;
        operand = 32'h5A5A_5A5A;
        shamt   = 5'd3;
        edges    = 1;
        busy_cyc = 0;
        ok       = 1'b1;
        while (!done && edges < 100) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            edges++;
        end
        if (!done) begin
            ok = 1'b0;
            n_applied++;
            n_miss++;
            $display("FAIL timeout: done not seen within %0d cycles", edges);
        end
    endtask

    task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] d,
                           input logic [4:0] s, input logic [31:0] exp);
        int   edges, bc, exp_edges, exp_busy;
        logic ok;
        exp_busy  = ((o == 2'b11) || (s == 0)) ? 0 : int'(s);
        exp_edges = exp_busy + 1;
        issue(o, d, s, edges, bc, ok);
        if (ok) begin
            check({name, " result"}, result, exp);
            check({name, " latency"}, edges, exp_edges);
            check({name, " busy_cycles"}, bc, exp_busy);
            check({name, " busy_in_done"}, {31'd0, busy}, 32'd0);
            @(negedge clk);
            check({name, " single_pulse"}, {31'd0, done}, 32'd0);
            check({name, " held"}, result, exp);
        end
    endtask

    initial begin
        int   edges, bc;
        logic ok;
        logic seen_done;

        vecs[0]  = '{"sll_1_31",      2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[1]  = '{"srl_4",         2'b01, 32'h8000_0000, 5'd4,  32'h0800_0000};
        vecs[2]  = '{"sra_neg_4",     2'b10, 32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[3]  = '{"sra_pos_4",     2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
        vecs[4]  = '{"srl_shamt0",    2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[5]  = '{"pass_7",        2'b11, 32'hDEAD_BEEF, 5'd7,  32'hDEAD_BEEF};
        vecs[6]  = '{"sra_31",        2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF};
        vecs[7]  = '{"srl_31",        2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[8]  = '{"sll_1",         2'b00, 32'h1234_5678, 5'd1,  32'h2468_ACF0};
        vecs[9]  = '{"sra_pos_1",     2'b10, 32'h1234_5678, 5'd1,  32'h091A_2B3C};
        vecs[10] = '{"sll_16",        2'b00, 32'hA5A5_A5A5, 5'd16, 32'hA5A5_0000};
        vecs[11] = '{"sra_30",        2'b10, 32'hC000_0000, 5'd30, 32'hFFFF_FFFF};

        rst = 1'b1; start = 1'b0; op = 2'b00; operand = '0; shamt = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy",   {31'd0, busy}, 32'd0);
        check("reset done",   {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        @(negedge clk);

        foreach (vecs[i])
            run_vec(vecs[i].name, vecs[i].op, vecs[i].operand, vecs[i].shamt, vecs[i].exp_result);

        // Start while busy: second request must be ignored.
        start = 1'b1; op = 2'b00; operand = 32'h0000_0003; shamt = 5'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("busy_ign held_result", result, 32'hFFFF_FFFF);
        start = 1'b1; operand = 32'hFFFF_FFFF; op = 2'b01; shamt = 5'd1;
        @(negedge clk);
        start = 1'b0;
        edges = 4;
        while (!done && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        check("busy_ign latency", edges, 9);
        check("busy_ign result", result, 32'h0000_0300);
        @(negedge clk);
        check("busy_ign single_pulse", {31'd0, done}, 32'd0);

        // Back-to-back: start accepted during the done cycle.
        issue(2'b00, 32'h0000_0001, 5'd2, edges, bc, ok);
        if (ok) begin
            check("b2b first result", result, 32'h0000_0004);
            issue(2'b01, 32'h0000_0100, 5'd8, edges, bc, ok);
            if (ok) begin
                check("b2b second latency", edges, 9);
                check("b2b second result", result, 32'h0000_0001);
                @(negedge clk);
                check("b2b single_pulse", {31'd0, done}, 32'd0);
            end
        end

        // Reset mid-operation discards the shift and clears result.
        start = 1'b1; op = 2'b10; operand = 32'h8000_0000; shamt = 5'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst busy",   {31'd0, busy}, 32'd0);
        check("midrst done",   {31'd0, done}, 32'd0);
        check("midrst result", result, 32'd0);
        seen_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("midrst no_done", {31'd0, seen_done}, 32'd0);
        run_vec("after_rst", 2'b10, 32'h8000_0000, 5'd20, 32'hFFFF_F800);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
